// File: rtl/key_command_decoder_pkg.sv
// Shared types for the key-command path: gameCommand tokens, key indices and
// the press priority encoder.
package key_command_decoder_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        HIT   = 2'd1,
        STAND = 2'd2,
        DEAL  = 2'd3
    } gameCommand;

    localparam int NUM_KEYS  = 3;
    localparam int KEY_HIT   = 0;
    localparam int KEY_STAND = 1;
    localparam int KEY_DEAL  = 2;

    // Highest-priority press wins: DEAL > STAND > HIT.
    function automatic gameCommand select_command(input logic [NUM_KEYS-1:0] press);
        gameCommand sel;
        sel = NONE;
        if (press[KEY_DEAL])
            sel = DEAL;
        else if (press[KEY_STAND])
            sel = STAND;
        else if (press[KEY_HIT])
            sel = HIT;
        return sel;
    endfunction

endpackage

// File: rtl/key_command_decoder_if.sv
// Valid/ready command channel from the key decoder to the game FSM.
interface key_command_decoder_if;
    import key_command_decoder_pkg::*;

    gameCommand cmd;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (output cmd, output cmd_valid, input cmd_ready);
    modport slave  (input cmd, input cmd_valid, output cmd_ready);

endinterface

// File: rtl/key_command_decoder_debouncer.sv
// One key: 2-flop synchroniser, optional debouncer (KEY_DEBOUNCE_EN) and
// press-edge detector. level/press are active-high.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic press
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cycles
        $error("key_debouncer: DEBOUNCE_CYCLES must be 1..255");
    end

    logic sync1_reg;
    logic sync2_reg;
    logic down;
    logic level_d_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= raw_n;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    logic [7:0] count_reg;
    logic [7:0] count_next;
    logic       stable_n_reg;
    logic       stable_n_next;

    // The count clears on agreement and also on the flip itself.
    always_comb begin
        count_next    = '0;
        stable_n_next = stable_n_reg;
        if (sync2_reg != stable_n_reg) begin
            if (count_reg == 8'(DEBOUNCE_CYCLES - 1))
                stable_n_next = sync2_reg;
            else
                count_next = count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg    <= '0;
            stable_n_reg <= 1'b1;
        end else begin
            count_reg    <= count_next;
            stable_n_reg <= stable_n_next;
        end
    end

    assign down = ~stable_n_reg;
`else
    assign down = ~sync2_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            level_d_reg <= 1'b0;
        else
            level_d_reg <= down;
    end

    assign level = down;
    assign press = down & ~level_d_reg;

endmodule

// File: rtl/key_command_decoder.sv
// Push-button front end: three debounced keys become single gameCommand tokens
// held in a one-entry output register. Debouncing is enabled by KEY_DEBOUNCE_EN.
module key_command_decoder
    import key_command_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_KEYS-1:0]   KEY,
    key_command_decoder_if.master cmd_if,
    output logic [NUM_KEYS-1:0]   keys_down,
    output logic                  cmd_dropped
);

    logic [NUM_KEYS-1:0] press;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk   (clk),
            .reset (reset),
            .raw_n (KEY[gi]),
            .level (keys_down[gi]),
            .press (press[gi])
        );
    end

    gameCommand cmd_reg;
    gameCommand cmd_next;
    logic       valid_reg;
    logic       valid_next;
    logic       dropped_reg;
    logic       dropped_next;
    logic       any_press;
    logic       multi_press;

    assign any_press   = |press;
    assign multi_press = (press[0] & press[1]) | (press[0] & press[2]) | (press[1] & press[2]);

    // A completing handshake frees the slot in the same cycle, so a
    // coinciding press reloads without a bubble.
    always_comb begin
        cmd_next     = cmd_reg;
        valid_next   = valid_reg;
        dropped_next = 1'b0;
        if (valid_reg && cmd_if.cmd_ready) begin
            valid_next = 1'b0;
            cmd_next   = NONE;
        end
        if (any_press) begin
            if (!valid_reg || cmd_if.cmd_ready) begin
                valid_next   = 1'b1;
                cmd_next     = select_command(press);
                dropped_next = multi_press;
            end else begin
                dropped_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_reg     <= NONE;
            valid_reg   <= 1'b0;
            dropped_reg <= 1'b0;
        end else begin
            cmd_reg     <= cmd_next;
            valid_reg   <= valid_next;
            dropped_reg <= dropped_next;
        end
    end

    assign cmd_if.cmd       = cmd_reg;
    assign cmd_if.cmd_valid = valid_reg;
    assign cmd_dropped      = dropped_reg;

endmodule

// File: doc/key_command_decoder.md
# key_command_decoder

Front-end conditioner between the board push-buttons and `blackjackGame`. It synchronises and debounces the three active-low `KEY` inputs and detects press edges. Each press becomes a single `gameCommand` token (HIT / STAND / DEAL), which is offered to the game FSM over a valid/ready handshake with one-entry holding. It is the producing end of the key-command path the game consumes.

## Interface
- `DEBOUNCE_CYCLES`, default 8: consecutive cycles a synchronised key must hold its new level before the stable level flips (1..255).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `KEY` in 3: raw buttons, active-low (0 = pressed). Bit 0 = HIT, bit 1 = STAND, bit 2 = DEAL.
- `cmd` out `gameCommand` (2): command token, valid only while `cmd_valid`.
- `cmd_valid` out 1: token held in output register.
- `cmd_ready` in 1: consumer accepts the token on any cycle with `cmd_valid && cmd_ready`.
- `keys_down` out 3: debounced levels, active-high (1 = pressed).
- `cmd_dropped` out 1: one-cycle pulse when a press event is discarded.

## Operation
- Per key: 2-flop synchroniser, then debouncer, then press-edge detector (stable up→down). Release edges and held keys produce nothing; there is no auto-repeat.
- Debouncer:
  - Counter increments each cycle the synchronised level differs from the stable level.
  - Counter clears on any cycle the two agree.
  - When the count reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles is ignored.
- Command encoding: NONE = 0, HIT = 1, STAND = 2, DEAL = 3.
- Output register (one entry):
  - Empty and press event: load the token and set `cmd_valid`.
  - Full and handshake completes: clear, or reload in the same cycle if a press event coincides, so no bubble.
  - Full, not accepted, press event: drop the event and pulse `cmd_dropped`; the held token is unchanged.
- Simultaneous press events in one cycle: priority DEAL > STAND > HIT. One token is accepted and the others are dropped, giving a single `cmd_dropped` pulse.
- `cmd` reads NONE whenever `cmd_valid` = 0.
- Reset:
  - Synchroniser flops are set to 1 (up), stable levels to up, counters to 0.
  - `cmd_valid` = 0, `cmd` = NONE, `keys_down` = 0, `cmd_dropped` = 0.
  - A key held low across reset release is treated as a fresh press after normal latency.
  - Reset mid-debounce or while `cmd_valid` discards all state. The pending token is lost and no `cmd_dropped` pulse is issued.

## Timing
- Edge 1 is the first rising edge that samples `KEY[i]` low, with `KEY[i]` held low throughout.
  - `keys_down[i]` rises after edge `DEBOUNCE_CYCLES`+2.
  - `cmd_valid` rises after edge `DEBOUNCE_CYCLES`+3 (edge 11 at the default).
- Release: `keys_down[i]` falls `DEBOUNCE_CYCLES`+2 edges after the first edge sampling high.
- Handshake: `cmd_valid` drops on the edge after acceptance unless reloaded.
  - `cmd` and `cmd_valid` are registered outputs with no combinational path from `cmd_ready`.
  - Once asserted, `cmd_valid` stays high and `cmd` stays stable until accepted.
- `cmd_dropped` is registered and asserts in the same cycle the token would have loaded.

## Configuration
- `KEY_DEBOUNCE_EN` defined: debouncers instantiated as above.
- `KEY_DEBOUNCE_EN` undefined:
  - Stable level = synchronised level and `DEBOUNCE_CYCLES` is unused.
  - `keys_down` rises after edge 2 and `cmd_valid` after edge 3.
  - Glitches of one cycle or longer produce commands.

## Structure
- `gameCommand.svh`: the 2-bit `gameCommand` type and the NONE/HIT/STAND/DEAL constants.
- Key index constants HIT = 0, STAND = 1, DEAL = 2 also live in a shared header, not local defines.
- Sub-module `key_debouncer`: one key's synchroniser, debounce counter and stable-level register (clk, reset, raw_n, level, press). Instantiated three times; the debounce logic is inside the `KEY_DEBOUNCE_EN` guard.
- Priority select, output register and drop logic stay in `key_command_decoder`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `KEY_DEBOUNCE_EN` defined unless stated.
- Hold `KEY[2]` low for 10 cycles, `cmd_ready` = 1 → `cmd_valid` high for exactly 1 cycle after edge 7 with `cmd` = 3; one token only despite the hold.
- Pulse `KEY[0]` low for 3 cycles, then high → no `cmd_valid`, `keys_down` stays 0.
- `KEY[0]` and `KEY[1]` fall in the same cycle, `cmd_ready` = 1 → `cmd` = 2 (STAND) and `cmd_dropped` pulses once in the same cycle.
- `cmd_ready` = 0, press HIT then, 20 cycles later, STAND:
  - `cmd` = 1 held and `cmd_dropped` pulses at the STAND event.
  - Raising `cmd_ready` afterwards yields exactly one token.
- Assert `reset` for 1 cycle while `cmd_valid` = 1 and `KEY[0]` is held low → `cmd_valid` = 0 next cycle; a new HIT token appears 7 edges after reset release.
- `KEY_DEBOUNCE_EN` undefined: 1-cycle low on `KEY[1]` → `cmd` = 2 valid after edge 3.
